// File: rtl/gecko_compute_sequencer.sv
// Host-side sequencer for the gecko compute block: streams a program image into the
// block over single-beat AXI writes, then releases the core and supervises its run.
module gecko_compute_sequencer #(
    parameter int                    ADDR_WIDTH       = 32,
    parameter int                    ADDR_SPACE_WIDTH = 13,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR        = '0,
    parameter int unsigned           TIMEOUT_CYCLES   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [31:0]           load_data,
    input  logic                  load_last,
    output logic                  axi_awvalid,
    input  logic                  axi_awready,
    output logic [ADDR_WIDTH-1:0] axi_awaddr,
    output logic [7:0]            axi_awlen,
    output logic [2:0]            axi_awsize,
    output logic [1:0]            axi_awburst,
    output logic                  axi_wvalid,
    input  logic                  axi_wready,
    output logic [31:0]           axi_wdata,
    output logic [3:0]            axi_wstrb,
    output logic                  axi_wlast,
    input  logic                  axi_bvalid,
    output logic                  axi_bready,
    input  logic [1:0]            axi_bresp,
    output logic                  core_rst,
    input  logic                  finished_flag,
    input  logic                  faulted_flag,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            status,
    output logic [31:0]           run_cycles
);

    localparam int              IDX_W         = ADDR_SPACE_WIDTH - 2;
    localparam logic [IDX_W-1:0] LAST_IDX     = '1;
    localparam logic [31:0]     TIMEOUT_LIMIT = 32'(TIMEOUT_CYCLES) - 32'd1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WRITE, S_RESP, S_RUN, S_DONE
    } state_t;

    typedef enum logic [2:0] {
        ST_NONE     = 3'd0,
        ST_FINISHED = 3'd1,
        ST_FAULTED  = 3'd2,
        ST_TIMEOUT  = 3'd3,
        ST_AXI_ERR  = 3'd4,
        ST_OVERFLOW = 3'd5
    } status_t;

    state_t           state_q, state_d;
    status_t          status_q, status_d;
    logic [IDX_W-1:0] word_index_q, word_index_d;
    logic [31:0]      run_cycles_q, run_cycles_d;
    logic             load_ready_q, load_ready_d;
    logic             awvalid_q, awvalid_d;
    logic             wvalid_q, wvalid_d;
    logic             bready_q, bready_d;
    logic             core_rst_q, core_rst_d;
    logic [31:0]      wdata_q;
    logic             last_q;
    logic             flags_live;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned
        // (which would infer a latch); the defaults hold the registered value.
        state_d      = state_q;
        status_d     = status_q;
        word_index_d = word_index_q;
        run_cycles_d = run_cycles_q;
        load_ready_d = load_ready_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;
        core_rst_d   = core_rst_q;
        // run_cycles is cleared on start, so zero marks the first RUN cycle
        flags_live   = (run_cycles_q != 32'd0);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_LOAD;
                    load_ready_d = 1'b1;
                    core_rst_d   = 1'b1;
                    word_index_d = '0;
                    status_d     = ST_NONE;
                    run_cycles_d = '0;
                end
            end
            S_LOAD: begin
                if (load_valid && load_ready_q) begin
                    state_d      = S_WRITE;
                    load_ready_d = 1'b0;
                    awvalid_d    = 1'b1;
                    wvalid_d     = 1'b1;
                end
            end
            S_WRITE: begin
                if (awvalid_q && axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && axi_wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = S_RESP;
                    bready_d = 1'b1;
                end
            end
            S_RESP: begin
                if (axi_bvalid && bready_q) begin
                    bready_d = 1'b0;
                    if (axi_bresp != 2'b00) begin
                        status_d = ST_AXI_ERR;
                        state_d  = S_DONE;
                    end else if (last_q) begin
                        state_d    = S_RUN;
                        core_rst_d = 1'b0;
                    end else if (word_index_q == LAST_IDX) begin
                        status_d = ST_OVERFLOW;
                        state_d  = S_DONE;
                    end else begin
                        word_index_d = word_index_q + 1'b1;
                        load_ready_d = 1'b1;
                        state_d      = S_LOAD;
                    end
                end
            end
            S_RUN: begin
                if (run_cycles_q != 32'hFFFF_FFFF) run_cycles_d = run_cycles_q + 32'd1;
                if (flags_live && faulted_flag) begin
                    status_d = ST_FAULTED;
                    state_d  = S_DONE;
                end else if (flags_live && finished_flag) begin
                    status_d = ST_FINISHED;
                    state_d  = S_DONE;
                end else if (TIMEOUT_CYCLES != 0 && run_cycles_q == TIMEOUT_LIMIT) begin
                    status_d = ST_TIMEOUT;
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            status_q     <= ST_NONE;
            word_index_q <= '0;
            run_cycles_q <= '0;
            load_ready_q <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            core_rst_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            status_q     <= status_d;
            word_index_q <= word_index_d;
            run_cycles_q <= run_cycles_d;
            load_ready_q <= load_ready_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            core_rst_q   <= core_rst_d;
        end
    end

    // NOTE: the captured payload has no reset; it is only consumed after a load
    // handshake has written it, so reset would add fan-out for no benefit.
    always_ff @(posedge clk) begin
        if (state_q == S_LOAD && load_valid && load_ready_q) begin
            wdata_q <= load_data;
            last_q  <= load_last;
        end
    end

    assign load_ready  = load_ready_q;
    assign axi_awvalid = awvalid_q;
    assign axi_awaddr  = BASE_ADDR + ADDR_WIDTH'({word_index_q, 2'b00});
    assign axi_awlen   = 8'd0;
    assign axi_awsize  = 3'd2;
    assign axi_awburst = 2'b01;
    assign axi_wvalid  = wvalid_q;
    assign axi_wdata   = wdata_q;
    assign axi_wstrb   = 4'hF;
    assign axi_wlast   = 1'b1;
    assign axi_bready  = bready_q;
    assign core_rst    = core_rst_q;
    assign busy        = (state_q == S_LOAD) || (state_q == S_WRITE) ||
                         (state_q == S_RESP) || (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign status      = status_q;
    assign run_cycles  = run_cycles_q;

endmodule

// File: tb/tb_gecko_compute_sequencer.sv
// Self-checking bench for gecko_compute_sequencer: scenario table plus hand-written
// reset-abort sequence, with a behavioural AXI write slave and address/data scoreboard.
module tb_gecko_compute_sequencer;

    localparam int              AW   = 32;
    localparam int              ASW  = 4;
    localparam logic [AW-1:0]   BASE = 32'h0;
    localparam int              TMO  = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic [31:0]   load_data = '0;
    logic          load_last = 1'b0;
    logic          axi_awvalid, axi_awready;
    logic [AW-1:0] axi_awaddr;
    logic [7:0]    axi_awlen;
    logic [2:0]    axi_awsize;
    logic [1:0]    axi_awburst;
    logic          axi_wvalid, axi_wready;
    logic [31:0]   axi_wdata;
    logic [3:0]    axi_wstrb;
    logic          axi_wlast;
    logic          axi_bvalid, axi_bready;
    logic [1:0]    axi_bresp;
    logic          core_rst;
    logic          finished_flag = 1'b0;
    logic          faulted_flag = 1'b0;
    logic          busy, done;
    logic [2:0]    status;
    logic [31:0]   run_cycles;

    always #5 clk = ~clk;

    gecko_compute_sequencer #(
        .ADDR_WIDTH(AW), .ADDR_SPACE_WIDTH(ASW), .BASE_ADDR(BASE), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data), .load_last(load_last),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
        .axi_awlen(axi_awlen), .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
        .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp),
        .core_rst(core_rst), .finished_flag(finished_flag), .faulted_flag(faulted_flag),
        .busy(busy), .done(done), .status(status), .run_cycles(run_cycles)
    );

    typedef struct {
        string name;
        int    n_words;
        bit    last;
        int    aw_delay;
        int    w_delay;
        int    err_word;
        int    fin_at;
        int    flt_at;
        bit    start_in_run;
        int    exp_acc;
        int    exp_writes;
        int    exp_status;
        int    exp_run;
        bit    exp_core_rst;
    } vec_t;

    int checks = 0;
    int failures = 0;

    // Slave configuration (written by the test) and observations (written by the slave)
    int            aw_delay = 0;
    int            w_delay = 0;
    int            err_word = -1;
    logic [1:0]    err_resp = 2'b10;
    int            scen_id = 0;
    logic [AW-1:0] obs_aw_q[$];
    logic [31:0]   obs_w_q[$];
    int            b_n = 0;
    int            viol_n = 0;

    logic [AW-1:0] exp_aw_q[$];
    logic [31:0]   exp_w_q[$];
    vec_t          vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(string name, int n, bit last, int awd, int wd, int errw,
                                int fin, int flt, bit sir, int acc, int wr, int st, int run,
                                bit crst);
        vec_t v;
        v.name = name; v.n_words = n; v.last = last; v.aw_delay = awd; v.w_delay = wd;
        v.err_word = errw; v.fin_at = fin; v.flt_at = flt; v.start_in_run = sir;
        v.exp_acc = acc; v.exp_writes = wr; v.exp_status = st; v.exp_run = run;
        v.exp_core_rst = crst;
        return v;
    endfunction

    // Behavioural AXI write slave; inputs change on negedge, handshakes land on the next posedge
    initial begin : axi_slave
        int seen_id, aw_cnt, w_cnt, aw_n, w_n;
        bit aw_hs, w_hs, b_hs, aw_prev, w_prev;
        seen_id = 0; aw_cnt = 0; w_cnt = 0; aw_n = 0; w_n = 0;
        aw_hs = 0; w_hs = 0; b_hs = 0; aw_prev = 0; w_prev = 0;
        axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0; axi_bresp = 2'b00;
        forever begin
            @(negedge clk);
            if (rst || scen_id != seen_id) begin
                seen_id = scen_id;
                aw_cnt = 0; w_cnt = 0; aw_n = 0; w_n = 0; b_n = 0; viol_n = 0;
                aw_hs = 0; w_hs = 0; b_hs = 0; aw_prev = 0; w_prev = 0;
                obs_aw_q.delete(); obs_w_q.delete();
                axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0; axi_bresp = 2'b00;
            end else begin
                if (aw_prev && !aw_hs && !axi_awvalid) viol_n++;
                if (aw_hs && axi_awvalid) viol_n++;
                if (w_prev && !w_hs && !axi_wvalid) viol_n++;
                if (w_hs && axi_wvalid) viol_n++;

                if (b_hs) begin
                    axi_bvalid = 1'b0;
                    b_n++;
                end
                if (!axi_bvalid && aw_n > b_n && w_n > b_n) begin
                    axi_bvalid = 1'b1;
                    axi_bresp  = (b_n == err_word) ? err_resp : 2'b00;
                end
                b_hs = axi_bvalid && axi_bready;

                aw_hs = 0;
                if (axi_awvalid && aw_cnt >= aw_delay) begin
                    axi_awready = 1'b1; aw_hs = 1; aw_cnt = 0; aw_n++;
                    obs_aw_q.push_back(axi_awaddr);
                end else begin
                    axi_awready = 1'b0;
                    if (axi_awvalid) aw_cnt++;
                end
                w_hs = 0;
                if (axi_wvalid && w_cnt >= w_delay) begin
                    axi_wready = 1'b1; w_hs = 1; w_cnt = 0; w_n++;
                    obs_w_q.push_back(axi_wdata);
                end else begin
                    axi_wready = 1'b0;
                    if (axi_wvalid) w_cnt++;
                end
                aw_prev = axi_awvalid;
                w_prev  = axi_wvalid;
            end
        end
    end

    task automatic stream(input int n, input bit last, input int budget, output int acc);
        int idx;
        logic [31:0] d;
        idx = 0;
        acc = 0;
        d = $urandom;
        for (int cyc = 0; cyc < budget && idx < n; cyc++) begin
            @(negedge clk);
            load_valid = 1'b1;
            load_data  = d;
            load_last  = last && (idx == n - 1);
            if (load_ready) begin
                exp_aw_q.push_back(BASE + 32'(4 * idx));
                exp_w_q.push_back(d);
                idx++;
                acc++;
                d = $urandom;
            end
        end
        @(negedge clk);
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic begin_scenario(input int awd, input int wd, input int errw);
        aw_delay = awd;
        w_delay  = wd;
        err_word = errw;
        exp_aw_q.delete();
        exp_w_q.delete();
        scen_id++;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_scenario(input vec_t v);
        int acc, c, budget;
        begin_scenario(v.aw_delay, v.w_delay, v.err_word);
        check({v.name, ":after_start"}, {busy, load_ready, core_rst, status, run_cycles},
              {1'b1, 1'b1, 1'b1, 3'd0, 32'd0});
        stream(v.n_words, v.last, 80, acc);
        c = 0;
        for (budget = 0; budget < 300; budget++) begin
            @(negedge clk);
            if (done) break;
            start = 1'b0;
            if (busy && !core_rst) begin
                c++;
                finished_flag = (v.fin_at != 0 && c >= v.fin_at);
                faulted_flag  = (v.flt_at != 0 && c >= v.flt_at);
                start         = v.start_in_run && (c == 3);
            end
        end
        finished_flag = 1'b0;
        faulted_flag  = 1'b0;
        start         = 1'b0;
        @(negedge clk);
        check({v.name, ":done_busy"}, {done, busy}, 2'b10);
        check({v.name, ":status"}, status, v.exp_status);
        check({v.name, ":run_cycles"}, run_cycles, v.exp_run);
        check({v.name, ":core_rst"}, core_rst, v.exp_core_rst);
        check({v.name, ":accepted"}, acc, v.exp_acc);
        check({v.name, ":aw_count"}, obs_aw_q.size(), v.exp_writes);
        check({v.name, ":w_count"}, obs_w_q.size(), v.exp_writes);
        check({v.name, ":b_count"}, b_n, v.exp_writes);
        check({v.name, ":valid_rules"}, viol_n, 0);
        for (int i = 0; i < exp_aw_q.size(); i++) begin
            if (i < obs_aw_q.size())
                check($sformatf("%s:awaddr%0d", v.name, i), obs_aw_q[i], exp_aw_q[i]);
            if (i < obs_w_q.size())
                check($sformatf("%s:wdata%0d", v.name, i), obs_w_q[i], exp_w_q[i]);
        end
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : test
        int acc;
        //         name                 n lst awd wd err fin flt sir acc wr st run crst
        vecs.push_back(mk("zero_wait_3w",   3, 1, 0, 0, -1, 10, 0, 0, 3, 3, 1, 10, 0));
        vecs.push_back(mk("aw_stall",       2, 1, 5, 0, -1,  4, 0, 1, 2, 2, 1,  4, 0));
        vecs.push_back(mk("w_stall",        2, 1, 0, 5, -1,  3, 0, 0, 2, 2, 1,  3, 0));
        vecs.push_back(mk("bresp_err",      3, 1, 2, 2,  1,  0, 0, 0, 2, 2, 4,  0, 1));
        vecs.push_back(mk("overflow",       5, 0, 0, 0, -1,  0, 0, 0, 4, 4, 5,  0, 1));
        vecs.push_back(mk("timeout",        1, 1, 0, 0, -1,  0, 0, 0, 1, 1, 3, 20, 0));
        vecs.push_back(mk("both_flags",     1, 1, 0, 0, -1,  5, 5, 0, 1, 1, 2,  5, 0));
        vecs.push_back(mk("full_image",     4, 1, 1, 0, -1,  2, 0, 0, 4, 4, 1,  2, 0));
        vecs.push_back(mk("fault_only",     2, 1, 0, 1, -1,  0, 7, 0, 2, 2, 2,  7, 0));
        vecs.push_back(mk("flag_first_cyc", 1, 1, 0, 0, -1,  1, 0, 0, 1, 1, 1,  2, 0));
        vecs.push_back(mk("flag_at_limit",  1, 1, 0, 0, -1, 20, 0, 0, 1, 1, 1, 20, 0));

        repeat (3) @(negedge clk);
        check("rst:handshakes", {axi_awvalid, axi_wvalid, axi_bready, load_ready}, 4'b0000);
        check("rst:core_busy_done", {core_rst, busy, done}, 3'b100);
        check("rst:status", status, 3'd0);
        check("rst:run_cycles", run_cycles, 32'd0);
        check("rst:awaddr", axi_awaddr, BASE);
        check("tied_fields", {axi_awlen, axi_awsize, axi_awburst, axi_wstrb, axi_wlast},
              {8'd0, 3'd2, 2'b01, 4'hF, 1'b1});
        rst = 1'b0;
        load_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("idle:load_ignored", {load_ready, busy, core_rst, axi_awvalid}, 4'b0010);
        load_valid = 1'b0;

        foreach (vecs[i]) run_scenario(vecs[i]);

        // Abort during WRITE: AW stalled, W already accepted
        begin_scenario(6, 0, -1);
        stream(1, 1'b0, 20, acc);
        check("abort:accepted", acc, 1);
        @(negedge clk);
        check("abort:aw_held_w_dropped", {busy, axi_awvalid, axi_wvalid}, 3'b110);
        #2 rst = 1'b1;
        #1;
        check("abort:handshakes", {axi_awvalid, axi_wvalid, axi_bready, load_ready}, 4'b0000);
        check("abort:state", {core_rst, busy, done, status}, {1'b1, 1'b0, 1'b0, 3'd0});
        check("abort:run_cycles", run_cycles, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_scenario(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
